// File: rtl/dct_quant_zigzag.sv
// Captures one 64-coefficient block, quantizes it with the JPEG Q50 luminance table
// by reciprocal multiply, and streams the results out in zigzag order.
module dct_quant_zigzag #(
    parameter int IN_W    = 32,
    parameter int FRAC    = 14,
    parameter int RECIP_W = 16,
    parameter int OUT_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [64*IN_W-1:0] din_flat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic [5:0]         out_index
);

    localparam int PROD_W = IN_W + RECIP_W + 1;
    localparam int SHIFT  = FRAC + RECIP_W;
    localparam logic [PROD_W-1:0] HALF    = PROD_W'(1) << (SHIFT - 1);
    localparam logic [PROD_W-1:0] MAX_POS = PROD_W'(2 ** (OUT_W - 1) - 1);
    localparam logic [PROD_W-1:0] MAX_NEG = PROD_W'(2 ** (OUT_W - 1));

    localparam int QTAB [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    // Zigzag walks the anti-diagonals: even ones travel up-right, odd ones down-left.
    function automatic logic [64*6-1:0] build_zz();
        logic [64*6-1:0] t;
        int p;
        int r;
        int c;
        t = '0;
        p = 0;
        for (int s = 0; s < 15; s++) begin
            for (int k = 0; k < 8; k++) begin
                r = (s % 2 == 0) ? 7 - k : k;
                c = s - r;
                if (c >= 0 && c < 8) begin
                    t[p*6 +: 6] = 6'(r * 8 + c);
                    p++;
                end
            end
        end
        return t;
    endfunction

    localparam logic [64*6-1:0] ZZ_TAB = build_zz();

    // Reciprocals are stored in output order so one index addresses both tables.
    function automatic logic [64*RECIP_W-1:0] build_recip_zz();
        logic [64*RECIP_W-1:0] t;
        int idx;
        t = '0;
        for (int p = 0; p < 64; p++) begin
            idx = int'(ZZ_TAB[p*6 +: 6]);
            t[p*RECIP_W +: RECIP_W] = RECIP_W'((2 ** (RECIP_W + 1) / QTAB[idx] + 1) / 2);
        end
        return t;
    endfunction

    localparam logic [64*RECIP_W-1:0] RECIP_ZZ = build_recip_zz();

    function automatic logic [OUT_W-1:0] quantize(input logic [IN_W-1:0] x,
                                                  input logic [RECIP_W-1:0] recip);
        logic signed [PROD_W-1:0] prod;
        logic [PROD_W-1:0] mag;
        logic [PROD_W-1:0] q_mag;
        prod  = PROD_W'($signed(x)) * PROD_W'($signed({1'b0, recip}));
        mag   = prod[PROD_W-1] ? $unsigned(-prod) : $unsigned(prod);
        q_mag = (mag + HALF) >> SHIFT;
        if (!prod[PROD_W-1]) begin
            quantize = (q_mag > MAX_POS) ? OUT_W'(MAX_POS) : OUT_W'(q_mag);
        end else begin
            quantize = (q_mag > MAX_NEG) ? OUT_W'(MAX_NEG) : OUT_W'(-q_mag);
        end
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [5:0]         out_index_q, out_index_d;
    logic [IN_W-1:0]    bank_q [64];
    logic [IN_W-1:0]    bank_d [64];
    logic [5:0]         nxt_pos;
    logic [5:0]         nxt_src;
    logic [RECIP_W-1:0] nxt_recip;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_index_d = out_index_q;
        bank_d      = bank_q;
        nxt_pos     = out_index_q + 6'd1;
        nxt_src     = ZZ_TAB[int'(nxt_pos)*6 +: 6];
        nxt_recip   = RECIP_ZZ[int'(nxt_pos)*RECIP_W +: RECIP_W];
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < 64; i++) begin
                        bank_d[i] = din_flat[i*IN_W +: IN_W];
                    end
                    // Position 0 is word 0, so it is quantized straight from the input bus.
                    state_d     = RUN;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_index_d = 6'd0;
                    out_last_d  = 1'b0;
                    out_data_d  = quantize(din_flat[IN_W-1:0], RECIP_ZZ[RECIP_W-1:0]);
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_index_d = 6'd0;
                        out_data_d  = '0;
                    end else begin
                        out_index_d = nxt_pos;
                        out_last_d  = (nxt_pos == 6'd63);
                        out_data_d  = quantize(bank_q[nxt_src], nxt_recip);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_index_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
        end
    end

    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed and randomized bench for dct_quant_zigzag with a Q50 zigzag quantizer model.
module tb_dct_quant_zigzag;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2047:0]  din_flat;
    logic           out_valid;
    logic           out_ready;
    logic [11:0]    out_data;
    logic           out_last;
    logic [5:0]     out_index;

    int vectors;
    int miscompares;

    logic [31:0] blk [64];
    logic [11:0] exp_q [$];

    int zz_tab [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    int qtab [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    dct_quant_zigzag dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_flat  (din_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_index (out_index)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: x/2^14 divided by Q, rounded half away from zero, via round(65536/Q).
    function automatic logic [11:0] model_q(input logic [31:0] x, input int q);
        longint xs;
        longint recip;
        longint prod;
        longint mag;
        longint r;
        xs    = longint'($signed(x));
        recip = longint'($rtoi(65536.0 / q + 0.5));
        prod  = xs * recip;
        mag   = (prod < 0) ? -prod : prod;
        r     = (mag + (longint'(1) << 29)) >> 30;
        if (prod < 0) r = -r;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return 12'(r);
    endfunction

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 32'h0;
    endtask

    task automatic exp_from_model();
        exp_q = {};
        for (int p = 0; p < 64; p++) exp_q.push_back(model_q(blk[zz_tab[p]], qtab[zz_tab[p]]));
    endtask

    task automatic exp_zero();
        exp_q = {};
        for (int p = 0; p < 64; p++) exp_q.push_back(12'h000);
    endtask

    // Driver: present blk and hold in_valid until the handshake edge.
    task automatic send_block();
        int cycles;
        bit taken;
        cycles = 0;
        taken  = 1'b0;
        for (int i = 0; i < 64; i++) din_flat[i*32 +: 32] = blk[i];
        in_valid = 1'b1;
        while (!taken && cycles < 200) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        if (!taken) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    // Consumer: accepts up to stop_at beats, checking each against exp_q.
    task automatic collect(input int hold_beats, input bit rand_ready, input int stop_at);
        int beats;
        int cycles;
        bit stalled;
        logic [11:0] held_data;
        logic [5:0]  held_idx;
        logic [11:0] exp;
        beats   = 0;
        cycles  = 0;
        stalled = 1'b0;
        held_data = '0;
        held_idx  = '0;
        while (beats < stop_at && cycles < 2000) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (beats < hold_beats) begin
                in_valid = 1'b1;
                din_flat = {64{$urandom()}};
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("out_valid[%0d]", beats), {31'b0, out_valid}, 32'd1);
            if (stalled) begin
                check($sformatf("stall_data[%0d]", beats), {20'b0, out_data}, {20'b0, held_data});
                check($sformatf("stall_index[%0d]", beats), {26'b0, out_index}, {26'b0, held_idx});
            end
            if (out_ready) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
                check($sformatf("data[%0d]", beats), {20'b0, out_data}, {20'b0, exp});
                check($sformatf("index[%0d]", beats), {26'b0, out_index}, 32'(beats));
                check($sformatf("last[%0d]", beats), {31'b0, out_last}, {31'b0, beats == 63});
                beats++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_data = out_data;
                held_idx  = out_index;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (beats < stop_at) check("stream_timeout", 32'(beats), 32'(stop_at));
    endtask

    task automatic check_block_end(input string tag);
        check({tag, "_end_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_end_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_single(input string tag, input logic [31:0] w0, input logic [11:0] e0);
        clear_blk();
        blk[0] = w0;
        exp_zero();
        exp_q[0] = e0;
        send_block();
        collect(0, 1'b0, 64);
        check_block_end(tag);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 3))
                0: blk[i] = 32'($urandom_range(0, 2 ** 25)) - 32'h0100_0000;
                1: blk[i] = $urandom();
                2: blk[i] = 32'h0;
                default: blk[i] = 32'($urandom_range(0, 2 ** 21)) - 32'h0010_0000;
            endcase
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        din_flat    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {20'b0, out_data}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        check("rst_out_index", {26'b0, out_index}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DC block
        run_single("dc", 32'h0010_0000, 12'd4);

        // Zigzag ordering of the first three AC positions
        clear_blk();
        blk[1]  = 32'h0002_C000;
        blk[8]  = 32'h0009_0000;
        blk[16] = 32'h0003_8000;
        exp_zero();
        exp_q[1] = 12'd1;
        exp_q[2] = 12'd3;
        exp_q[3] = 12'd1;
        send_block();
        collect(0, 1'b0, 64);
        check_block_end("zigzag");

        // Rounding and sign
        run_single("round_pos", 32'h0006_0000, 12'd2);
        run_single("round_neg", 32'hFFFA_0000, 12'hFFE);
        run_single("round_down", 32'h0005_C000, 12'd1);

        // Saturation
        run_single("sat_pos", 32'h7FFF_FFFF, 12'h7FF);
        run_single("sat_neg", 32'h8000_0000, 12'h800);

        // Backpressure with in_valid held high during the run
        clear_blk();
        blk[0] = 32'h0010_0000;
        exp_zero();
        exp_q[0] = 12'd4;
        send_block();
        collect(40, 1'b1, 64);
        check_block_end("backpressure");

        // Random blocks against the reference model
        for (int b = 0; b < 4; b++) begin
            fill_random();
            exp_from_model();
            send_block();
            collect(0, 1'b1, 64);
            check_block_end($sformatf("rand%0d", b));
        end

        // Reset mid-block
        clear_blk();
        blk[0] = 32'h0010_0000;
        exp_zero();
        exp_q[0] = 12'd4;
        send_block();
        collect(0, 1'b0, 20);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_index", {26'b0, out_index}, 32'd0);
        check("midrst_out_last", {31'b0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_out_valid", {31'b0, out_valid}, 32'd0);
        fill_random();
        exp_from_model();
        send_block();
        collect(0, 1'b1, 64);
        check_block_end("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
